hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline control counterpart to the forwarding logic in the 5-stage core.
- Forwarding resolves hazards by supplying data. This block resolves the hazards forwarding cannot: load-use, memory wait, control redirect and halt.
- It drives per-latch enable and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- It is a small FSM between the hazard sources (ID/EX/MEM stage fields, cache hit lines) and the pipeline latches.

Parameters:
REG_W, 5, register index width
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
id_rs  in  REG_W  rs field of instruction in ID
id_rt  in  REG_W  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_W  destination register of EX instruction
id_jump  in  1  J/JAL/JR decoded in ID
mem_branch_taken  in  1  branch resolved taken in MEM
mem_dreq  in  1  MEM stage has dmemREN or dmemWEN
dhit  in  1  data memory done this cycle
ihit  in  1  instruction fetch done this cycle
mem_halt  in  1  HALT reached MEM
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush  out  1 each  latch clears (insert bubble); a flush overrides the latch's enable
halted  out  1  core stopped

Behaviour:
- States (from the shared package): RUN, LU_STALL, MEM_WAIT, HALTED. All outputs are combinational from state and inputs. State is registered.
- Reset: while nRST=0 at the clock edge, the next state is RUN.
  - During any cycle with nRST=0, all enables are 0, all flushes are 1 and halted is 0.
  - Reset is honoured from any state, including MEM_WAIT and HALTED.
- Default (no hazard): all enables 1, all flushes 0.
- RUN / LU_STALL evaluation uses the following priority, highest first:
  1. mem_halt:
     - all enables 0, next state HALTED.
  2. mem_dreq & !dhit:
     - all enables 0, flushes 0, next state MEM_WAIT.
  3. mem_branch_taken:
     - pc_en=ihit, ifid_flush=1, idex_flush=1, exmem_flush=1, next state RUN.
  4. Load-use, i.e. ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)):
     - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
     - next state LU_STALL.
  5. !ihit:
     - pc_en=0, ifid_flush=1, others enabled, state unchanged.
  6. id_jump:
     - ifid_flush=1, pc_en=1.
- LU_STALL:
  - Lasts exactly one cycle, then returns to RUN unless a higher-priority event occurs.
  - The bubble now in EX has ex_memread=0, so back-to-back load-use stalls on the same load cannot occur.
  - A second dependent load re-triggers rule 4 normally.
- Register 0 never causes a stall.
- MEM_WAIT:
  - While !dhit: all enables 0, flushes 0.
  - On dhit: evaluate the RUN rules with rule 2 masked (dhit satisfied); the next state comes from those rules, otherwise RUN.
  - mem_halt cannot arrive in MEM_WAIT because MEM is frozen.
- HALTED:
  - All enables 0, flushes 0, halted=1. Absorbing until reset.
- Simultaneous events:
  - The priority list decides.
  - A branch flush beats load-use: the dependent instruction is squashed anyway, so no stall is taken.
  - ihit low together with a branch: pc_en=0, flushes still asserted.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds outputs stall_cycles [CNT_W], flush_events [CNT_W] and lu_stalls [CNT_W].
  - stall_cycles increments on any cycle with pc_en=0 and state!=HALTED.
  - flush_events increments on rule 3 firing.
  - lu_stalls increments on entry to LU_STALL.
  - All counters reset to 0 and saturate at all-ones.
- HAZARD_PERF_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- hazard_pkg: hazard_state_t enum (RUN, LU_STALL, MEM_WAIT, HALTED), REG_W constant, regbits_t typedef.
- One sub-module, load_use_detect: purely combinational comparator producing the rule-4 condition. Instantiated once.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with random inputs -> all enables 0, flushes 1, halted 0. After release with ihit=1 and no hazards -> all enables 1.
- Load-use: ex_memread=1, ex_rd=8, id_rs=8 -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; next cycle all enables 1. Repeat with ex_rd=0 -> no stall.
- Memory wait: mem_dreq=1, dhit=0 for 3 cycles then dhit=1 -> enables 0 for 3 cycles, all 1 on the dhit cycle, state RUN.
- Branch vs load-use: mem_branch_taken=1 and the load-use condition true together -> ifid/idex/exmem_flush=1, pc_en=1, no LU_STALL entered.
- Halt: mem_halt=1 -> halted=1 and all enables 0 for 10 cycles; nRST=0 for one edge -> state RUN.
- HAZARD_PERF_EN: 2 load-use stalls and 1 branch -> lu_stalls=2, flush_events=1, stall_cycles=2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, register
// index type and the packed bundle of latch enables/flushes.
// Optional build macro: HAZARD_PERF_EN (adds performance counters).
package hazard_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } hazard_state_t;

  // Field order matches the pipeline order, PC first, halted last.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic halted;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = ctrl_t'(9'b11111_000_0);
  localparam ctrl_t CTRL_RESET  = ctrl_t'(9'b00000_111_0);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(9'b00000_000_0);
  localparam ctrl_t CTRL_HALT   = ctrl_t'(9'b00000_000_1);

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the hazard sources / pipeline latches and the hazard unit.
// slave: the hazard unit. master: the pipeline side driving the sources.
// Optional build macro: HAZARD_PERF_EN (adds performance counter outputs).
interface hazard_unit_if;

  hazard_pkg::regbits_t id_rs;
  hazard_pkg::regbits_t id_rt;
  logic                 id_uses_rt;
  logic                 ex_memread;
  hazard_pkg::regbits_t ex_rd;
  logic                 id_jump;
  logic                 mem_branch_taken;
  logic                 mem_dreq;
  logic                 dhit;
  logic                 ihit;
  logic                 mem_halt;

  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic halted;

`ifdef HAZARD_PERF_EN
  logic [hazard_pkg::CNT_W-1:0] stall_cycles;
  logic [hazard_pkg::CNT_W-1:0] flush_events;
  logic [hazard_pkg::CNT_W-1:0] lu_stalls;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, id_jump,
           mem_branch_taken, mem_dreq, dhit, ihit, mem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted,
           stall_cycles, flush_events, lu_stalls
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, id_jump,
           mem_branch_taken, mem_dreq, dhit, ihit, mem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted,
           stall_cycles, flush_events, lu_stalls
  );
`else
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, id_jump,
           mem_branch_taken, mem_dreq, dhit, ihit, mem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, id_jump,
           mem_branch_taken, mem_dreq, dhit, ihit, mem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted
  );
`endif

endinterface

// File: rtl/load_use_detect.sv
// Load-use comparator: the load in EX writes a register the instruction
// in ID reads. Register 0 is hardwired, so it never creates a dependency.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic     ex_memread,
  input  regbits_t ex_rd,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_uses_rt,
  output logic     load_use
);

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: resolves load-use, memory wait, branch
// redirect and halt by driving latch enables/flushes. Outputs are
// combinational from state and inputs; only the state is registered.
// Optional build macro: HAZARD_PERF_EN (stall/flush/load-use counters).
module hazard_unit
  import hazard_pkg::*;
(
  input logic       CLK,
  input logic       nRST,
  hazard_unit_if.slave hz
);

  hazard_state_t state;
  hazard_state_t state_nxt;
  ctrl_t         ctrl;
  logic          lu_hit;

  load_use_detect u_load_use_detect (
    .ex_memread (hz.ex_memread),
    .ex_rd      (hz.ex_rd),
    .id_rs      (hz.id_rs),
    .id_rt      (hz.id_rt),
    .id_uses_rt (hz.id_uses_rt),
    .load_use   (lu_hit)
  );

  // Priority evaluation of hazards; MEM_WAIT with dhit falls through to the
  // RUN rules, where the memory-wait rule is naturally false.
  always_comb begin
    ctrl      = CTRL_RUN;
    state_nxt = RUN;
    if (!nRST) begin
      ctrl = CTRL_RESET;
    end else if (state == HALTED) begin
      ctrl      = CTRL_HALT;
      state_nxt = HALTED;
    end else if ((state == MEM_WAIT) && !hz.dhit) begin
      ctrl      = CTRL_FREEZE;
      state_nxt = MEM_WAIT;
    end else if (hz.mem_halt) begin
      ctrl      = CTRL_FREEZE;
      state_nxt = HALTED;
    end else if (hz.mem_dreq && !hz.dhit) begin
      ctrl      = CTRL_FREEZE;
      state_nxt = MEM_WAIT;
    end else if (hz.mem_branch_taken) begin
      // Squashes the dependent instruction too, so no load-use stall.
      ctrl.pc_en       = hz.ihit;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (lu_hit) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
      state_nxt       = LU_STALL;
    end else if (!hz.ihit) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_flush = 1'b1;
    end else if (hz.id_jump) begin
      ctrl.ifid_flush = 1'b1;
    end
  end

  // State register with synchronous reset to RUN.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign hz.pc_en       = ctrl.pc_en;
  assign hz.ifid_en     = ctrl.ifid_en;
  assign hz.idex_en     = ctrl.idex_en;
  assign hz.exmem_en    = ctrl.exmem_en;
  assign hz.memwb_en    = ctrl.memwb_en;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_flush  = ctrl.idex_flush;
  assign hz.exmem_flush = ctrl.exmem_flush;
  assign hz.halted      = ctrl.halted;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] lu_q;

  // Saturating counters. Outside reset, exmem_flush is raised only by the
  // branch rule and LU_STALL is entered only by the load-use rule.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
      lu_q    <= '0;
    end else begin
      if (!ctrl.pc_en && (state != HALTED) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (ctrl.exmem_flush && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
      if ((state_nxt == LU_STALL) && (lu_q != '1))
        lu_q <= lu_q + 1'b1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
  assign hz.lu_stalls    = lu_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed steps followed by random traffic, each cycle compared against a
// behavioural model of the hazard priority rules.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  hazard_unit_if hz();

  hazard_unit dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (hz)
  );

  int total = 0;
  int bad   = 0;

  // Model state: core stopped / waiting on data memory.
  bit m_halted = 1'b0;
  bit m_wait   = 1'b0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  int unsigned m_lu    = 0;

  // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes, halted}
  function automatic logic [8:0] observed();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.halted};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic predict(output logic [8:0] o, output bit nh, output bit nw,
                         output bit br, output bit lu);
    bit dep;
    dep = hz.ex_memread && (hz.ex_rd != 0) &&
          ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
    nh = m_halted; nw = m_wait; br = 1'b0; lu = 1'b0;
    o  = 9'b11111_000_0;
    if (!nRST) begin
      o = 9'b00000_111_0; nh = 1'b0; nw = 1'b0;
    end else if (m_halted) begin
      o = 9'b00000_000_1;
    end else if (m_wait && !hz.dhit) begin
      o = 9'b0;
    end else begin
      nw = 1'b0;
      if (hz.mem_halt) begin
        o = 9'b0; nh = 1'b1;
      end else if (hz.mem_dreq && !hz.dhit) begin
        o = 9'b0; nw = 1'b1;
      end else if (hz.mem_branch_taken) begin
        o = {hz.ihit, 4'b1111, 3'b111, 1'b0}; br = 1'b1;
      end else if (dep) begin
        o = 9'b00111_010_0; lu = 1'b1;
      end else if (!hz.ihit) begin
        o = 9'b01111_100_0;
      end else if (hz.id_jump) begin
        o = 9'b11111_100_0;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cyc(input string tag, input bit use_want = 1'b0, input logic [8:0] want = 9'b0);
    logic [8:0] o;
    bit nh, nw, br, lu;
    @(negedge CLK);
    predict(o, nh, nw, br, lu);
    check(tag, observed(), o);
    if (use_want) check({tag, "_dir"}, observed(), want);
    @(posedge CLK);
    if (!nRST) begin
      m_stall = 0; m_flush = 0; m_lu = 0;
    end else begin
      if (!o[8] && !m_halted) m_stall++;
      if (br) m_flush++;
      if (lu) m_lu++;
    end
    m_halted = nh;
    m_wait   = nw;
    #1;
  endtask

  task automatic quiet();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0;
    hz.ex_memread = 1'b0; hz.ex_rd = '0; hz.id_jump = 1'b0;
    hz.mem_branch_taken = 1'b0; hz.mem_dreq = 1'b0; hz.dhit = 1'b0;
    hz.ihit = 1'b1; hz.mem_halt = 1'b0;
  endtask

  task automatic randomize_inputs(input int halt_pct);
    hz.id_rs            = regbits_t'($urandom_range(0, 3));
    hz.id_rt            = regbits_t'($urandom_range(0, 3));
    hz.ex_rd            = regbits_t'($urandom_range(0, 3));
    hz.id_uses_rt       = ($urandom_range(0, 1) == 1);
    hz.ex_memread       = ($urandom_range(0, 99) < 40);
    hz.id_jump          = ($urandom_range(0, 99) < 15);
    hz.mem_branch_taken = ($urandom_range(0, 99) < 15);
    hz.mem_dreq         = ($urandom_range(0, 99) < 30);
    hz.dhit             = ($urandom_range(0, 99) < 50);
    hz.ihit             = ($urandom_range(0, 99) < 80);
    hz.mem_halt         = ($urandom_range(0, 99) < halt_pct);
  endtask

  task automatic lu_8();
    quiet();
    hz.ex_memread = 1'b1; hz.ex_rd = 5'd8; hz.id_rs = 5'd8;
  endtask

  initial begin
    // Reset with random inputs.
    nRST = 1'b0;
    randomize_inputs(20);
    cyc("reset0", 1'b1, 9'b00000_111_0);
    randomize_inputs(20);
    cyc("reset1", 1'b1, 9'b00000_111_0);
    nRST = 1'b1;
    quiet();
    cyc("run_idle", 1'b1, 9'b11111_000_0);

`ifdef HAZARD_PERF_EN
    check_cnt("perf_rst_stall", hz.stall_cycles, 32'd0);
    lu_8();            cyc("perf_lu_a");
    quiet();           cyc("perf_gap_a");
    lu_8();            cyc("perf_lu_b");
    quiet();           cyc("perf_gap_b");
    quiet(); hz.mem_branch_taken = 1'b1; cyc("perf_br");
    quiet();           cyc("perf_idle");
    check_cnt("perf_lu_stalls",    hz.lu_stalls,    32'd2);
    check_cnt("perf_flush_events", hz.flush_events, 32'd1);
    check_cnt("perf_stall_cycles", hz.stall_cycles, 32'd2);
`endif

    // Load-use on r8: one stall cycle, then the bubble lets ID proceed.
    lu_8();
    cyc("lu_stall", 1'b1, 9'b00111_010_0);
    quiet();
    cyc("lu_after", 1'b1, 9'b11111_000_0);
    // Load to r0 never stalls.
    quiet(); hz.ex_memread = 1'b1; hz.ex_rd = '0; hz.id_rs = '0;
    cyc("lu_r0", 1'b1, 9'b11111_000_0);
    // rt dependency only counts when rt is a source.
    quiet(); hz.ex_memread = 1'b1; hz.ex_rd = 5'd5; hz.id_rt = 5'd5;
    cyc("rt_unused", 1'b1, 9'b11111_000_0);
    hz.id_uses_rt = 1'b1;
    cyc("rt_used", 1'b1, 9'b00111_010_0);

    // Memory wait: three frozen cycles, released on dhit.
    quiet(); hz.mem_dreq = 1'b1; hz.dhit = 1'b0;
    cyc("mw0", 1'b1, 9'b0);
    cyc("mw1", 1'b1, 9'b0);
    cyc("mw2", 1'b1, 9'b0);
    hz.dhit = 1'b1;
    cyc("mw_hit", 1'b1, 9'b11111_000_0);
    quiet();
    cyc("mw_run", 1'b1, 9'b11111_000_0);

    // Branch beats load-use.
    lu_8(); hz.mem_branch_taken = 1'b1;
    cyc("br_vs_lu", 1'b1, 9'b11111_111_0);
    quiet();
    cyc("br_after", 1'b1, 9'b11111_000_0);
    // Branch with fetch miss: PC held, flushes still asserted.
    quiet(); hz.mem_branch_taken = 1'b1; hz.ihit = 1'b0;
    cyc("br_imiss", 1'b1, 9'b01111_111_0);
    quiet(); hz.ihit = 1'b0;
    cyc("imiss", 1'b1, 9'b01111_100_0);
    quiet(); hz.id_jump = 1'b1;
    cyc("jump", 1'b1, 9'b11111_100_0);

    // Halt is absorbing until reset.
    quiet(); hz.mem_halt = 1'b1;
    cyc("halt_entry", 1'b1, 9'b0);
    for (int i = 0; i < 10; i++) begin
      randomize_inputs(20);
      cyc("halted", 1'b1, 9'b00000_000_1);
    end
    nRST = 1'b0;
    cyc("halt_reset", 1'b1, 9'b00000_111_0);
    nRST = 1'b1; quiet();
    cyc("halt_release", 1'b1, 9'b11111_000_0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs(2);
      nRST = ($urandom_range(0, 99) >= 3);
      cyc("rand");
    end

`ifdef HAZARD_PERF_EN
    @(negedge CLK);
    check_cnt("rand_stall_cycles", hz.stall_cycles, m_stall);
    check_cnt("rand_flush_events", hz.flush_events, m_flush);
    check_cnt("rand_lu_stalls",    hz.lu_stalls,    m_lu);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
